// File: rtl/stack_arbiter.sv
// Purpose : shares one LIFO stack between NUM_REQ requesters, round-robin, one op in flight.
// Latency : from the grant cycle, push/error ack at +2 cycles, pop ack at +3 cycles.
// Backpress: requests are level-held until req_ack; others wait in IDLE; busy high while not IDLE.
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   req_push/req_pop/req_data per-requester level requests and push data (slice i = requester i)
//   req_ack/rsp_data/rsp_err  one-hot completion pulse with popped word and error flag
//   busy                     high whenever a transaction is in flight
//   stk_push/stk_pop/stk_inp_data  single-cycle strobes and push word to the stack
//   stk_out_data/stk_empty/stk_full registered pop word (cycle after stk_pop) and status flags
// Optional: define STACK_ARB_STATS_EN to add saturating 16-bit stat_push_cnt, stat_pop_cnt,
//   stat_err_cnt outputs counting completed pushes, pops and errors.
module stack_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_push,
   input  logic [NUM_REQ-1:0]            req_pop,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rsp_err,
   output logic                          busy,
   output logic                          stk_push,
   output logic                          stk_pop,
   output logic [DATA_WIDTH-1:0]         stk_inp_data,
   input  logic [DATA_WIDTH-1:0]         stk_out_data,
   input  logic                          stk_empty,
   input  logic                          stk_full
`ifdef STACK_ARB_STATS_EN
   ,
   output logic [15:0]                   stat_push_cnt,
   output logic [15:0]                   stat_pop_cnt,
   output logic [15:0]                   stat_err_cnt
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PW:0]   NREQ_W = (PW+1)'(NUM_REQ);
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

   // DEPTH only documents the attached stack; full/empty come from the stack itself.
   if (NUM_REQ < 2 || DEPTH < 1) begin : g_param_check
      $error("stack_arbiter: NUM_REQ must be >= 2 and DEPTH >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_POP, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           rr_q;
   logic [PW-1:0]           win_q;
   logic                    push_q, pop_q;
   logic [DATA_WIDTH-1:0]   data_q;

   logic [NUM_REQ-1:0]      pending;
   logic                    grant_vld;
   logic [PW-1:0]           grant_idx;
   logic [PW:0]             scan;
   logic                    ok_push, ok_pop;

   assign pending = req_push | req_pop;

   // Scan from rr_q upward with wrap; first pending index wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_q} + (PW+1)'(k);
         if (scan >= NREQ_W) scan = scan - NREQ_W;
         if (!grant_vld && pending[scan[PW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan[PW-1:0];
         end
      end
   end

   // A request with both push and pop set is malformed and never strobes the stack.
   assign ok_push = push_q & ~pop_q & ~stk_full;
   assign ok_pop  = pop_q & ~push_q & ~stk_empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      case (state_q)
         S_IDLE:     if (grant_vld) state_d = S_ISSUE;
         S_ISSUE: begin
            if (ok_pop) begin
               stk_pop = 1'b1;
               state_d = S_WAIT_POP;
            end else begin
               stk_push = ok_push;
               state_d  = S_RESP;
            end
         end
         S_WAIT_POP: state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   assign stk_inp_data = stk_push ? data_q : '0;
   assign busy         = (state_q != S_IDLE);

   always_comb begin
      req_ack = '0;
      if (state_q == S_RESP) req_ack[win_q] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_q     <= '0;
         win_q    <= '0;
         push_q   <= 1'b0;
         pop_q    <= 1'b0;
         data_q   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (state_q == S_IDLE && grant_vld) begin
            win_q  <= grant_idx;
            push_q <= req_push[grant_idx];
            pop_q  <= req_pop[grant_idx];
            data_q <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_q   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PW'(1);
         end
         if (state_q == S_ISSUE)    rsp_err  <= ~(ok_push | ok_pop);
         // rsp_data only changes on a pop, so push/error acks show the last popped word.
         if (state_q == S_WAIT_POP) rsp_data <= stk_out_data;
      end
   end

`ifdef STACK_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_push_cnt <= '0;
         stat_pop_cnt  <= '0;
         stat_err_cnt  <= '0;
      end else if (state_q == S_RESP) begin
         if (rsp_err) begin
            if (stat_err_cnt != 16'hFFFF) stat_err_cnt <= stat_err_cnt + 16'd1;
         end else if (push_q) begin
            if (stat_push_cnt != 16'hFFFF) stat_push_cnt <= stat_push_cnt + 16'd1;
         end else begin
            if (stat_pop_cnt != 16'hFFFF) stat_pop_cnt <= stat_pop_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
